// File: rtl/vanilla_exe_bubble_profiler.sv
// Per-type EXE bubble profiler: counts bubbles per type code, tracks each type's last PC,
// and on a trigger snapshots everything and drains it one entry per valid/ready handshake.
module vanilla_exe_bubble_profiler #(
   parameter int pc_width_p       = 32,
   parameter int num_types_p      = 32,
   parameter int no_bubble_code_p = 31,
   parameter int counter_width_p  = 32,
   parameter int clear_on_dump_p  = 1
) (
   input  logic                               clk_i,
   input  logic                               reset_n_i,
   input  logic                               stall_all_i,
   input  logic [31:0]                        exe_bubble_type_i,
   input  logic [pc_width_p-1:0]              exe_bubble_pc_i,
   input  logic                               trigger_i,
   output logic                               busy_o,
   output logic                               dump_v_o,
   input  logic                               dump_ready_i,
   output logic [$clog2(num_types_p+1)-1:0]   dump_idx_o,
   output logic [counter_width_p-1:0]         dump_count_o,
   output logic [pc_width_p-1:0]              dump_pc_o,
   output logic                               dump_last_o
);

   localparam int bins_lp      = num_types_p + 1;
   localparam int idx_width_lp = $clog2(num_types_p + 1);

   typedef enum logic [0:0] {idle_s, dump_s} state_e;

   state_e                    state_q, state_d;
   logic [idx_width_lp-1:0]   idx_q, idx_d;
   logic [counter_width_p-1:0] cnt_q      [bins_lp];
   logic [counter_width_p-1:0] cnt_d      [bins_lp];
   logic [pc_width_p-1:0]      pc_q       [bins_lp];
   logic [pc_width_p-1:0]      pc_d       [bins_lp];
   logic [counter_width_p-1:0] snap_cnt_q [bins_lp];
   logic [counter_width_p-1:0] snap_cnt_d [bins_lp];
   logic [pc_width_p-1:0]      snap_pc_q  [bins_lp];
   logic [pc_width_p-1:0]      snap_pc_d  [bins_lp];

   logic                    sample_v;
   logic                    take_snap;
   logic [idx_width_lp-1:0] bin;

   // Codes beyond the known range all fold into the last (unknown) bin.
   assign sample_v  = !stall_all_i && (exe_bubble_type_i != 32'(no_bubble_code_p));
   assign bin       = (exe_bubble_type_i < 32'(num_types_p)) ? idx_width_lp'(exe_bubble_type_i)
                                                             : idx_width_lp'(num_types_p);
   assign take_snap = (state_q == idle_s) && trigger_i;

   // Handshake: an entry moves when dump_v_o && dump_ready_i at a rising edge; while
   // dump_ready_i is low the presented entry is held unchanged.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      pc_d       = pc_q;
      snap_cnt_d = snap_cnt_q;
      snap_pc_d  = snap_pc_q;

      if (take_snap) begin
         snap_cnt_d = cnt_q;
         snap_pc_d  = pc_q;
         state_d    = dump_s;
         idx_d      = '0;
         if (clear_on_dump_p != 0) begin
            for (int i = 0; i < bins_lp; i++) cnt_d[i] = '0;
         end
      end

      // Reads cnt_d so that an event on a clearing trigger cycle starts the new interval at 1.
      if (sample_v) begin
         if (cnt_d[bin] != '1) cnt_d[bin] = cnt_d[bin] + counter_width_p'(1);
         pc_d[bin] = exe_bubble_pc_i;
      end

      if ((state_q == dump_s) && dump_ready_i) begin
         if (idx_q == idx_width_lp'(num_types_p)) state_d = idle_s;
         else                                     idx_d   = idx_q + idx_width_lp'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q <= idle_s;
         idx_q   <= '0;
         for (int i = 0; i < bins_lp; i++) begin
            cnt_q[i]      <= '0;
            pc_q[i]       <= '0;
            snap_cnt_q[i] <= '0;
            snap_pc_q[i]  <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         pc_q       <= pc_d;
         snap_cnt_q <= snap_cnt_d;
         snap_pc_q  <= snap_pc_d;
      end
   end

   assign busy_o       = (state_q == dump_s);
   assign dump_v_o     = (state_q == dump_s);
   assign dump_idx_o   = dump_v_o ? idx_q : '0;
   assign dump_count_o = dump_v_o ? snap_cnt_q[idx_q] : '0;
   assign dump_pc_o    = dump_v_o ? snap_pc_q[idx_q] : '0;
   assign dump_last_o  = dump_v_o && (idx_q == idx_width_lp'(num_types_p));

endmodule

// File: tb/tb_vanilla_exe_bubble_profiler.sv
// Bench for vanilla_exe_bubble_profiler: a default instance and a narrow (4-bit, no-clear)
// instance share one stimulus stream and are scored against a queue-based profile model.
module tb_vanilla_exe_bubble_profiler;

   localparam int nt_lp   = 32;
   localparam int bins_lp = nt_lp + 1;

   typedef struct packed {
      logic [5:0]  idx;
      logic [31:0] cnt_a;
      logic [3:0]  cnt_b;
      logic [31:0] pc;
      logic        last;
   } entry_t;

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, stall, trig, ready;
   logic [31:0] typ, pc;

   logic        a_busy, a_v, a_last, b_busy, b_v, b_last;
   logic [5:0]  a_idx, b_idx;
   logic [31:0] a_cnt, a_pc, b_pc;
   logic [3:0]  b_cnt;

   vanilla_exe_bubble_profiler dut_a (
      .clk_i(clk), .reset_n_i(rst_n), .stall_all_i(stall),
      .exe_bubble_type_i(typ), .exe_bubble_pc_i(pc), .trigger_i(trig),
      .busy_o(a_busy), .dump_v_o(a_v), .dump_ready_i(ready), .dump_idx_o(a_idx),
      .dump_count_o(a_cnt), .dump_pc_o(a_pc), .dump_last_o(a_last));

   vanilla_exe_bubble_profiler #(.counter_width_p(4), .clear_on_dump_p(0)) dut_b (
      .clk_i(clk), .reset_n_i(rst_n), .stall_all_i(stall),
      .exe_bubble_type_i(typ), .exe_bubble_pc_i(pc), .trigger_i(trig),
      .busy_o(b_busy), .dump_v_o(b_v), .dump_ready_i(ready), .dump_idx_o(b_idx),
      .dump_count_o(b_cnt), .dump_pc_o(b_pc), .dump_last_o(b_last));

   // reference model: live bins and a queue of entries still owed by the current dump
   logic [31:0] live_a [bins_lp];
   logic [3:0]  live_b [bins_lp];
   logic [31:0] lpc    [bins_lp];
   entry_t      exp_q[$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < bins_lp; i++) begin
         live_a[i] = '0;
         live_b[i] = '0;
         lpc[i]    = '0;
      end
      exp_q.delete();
   endtask

   // scoreboard: outputs seen before an edge must match the head of the expected queue
   task automatic compare_outputs();
      logic   busy_m;
      entry_t e;
      busy_m = (exp_q.size() != 0);
      check("a_busy", 64'(a_busy), 64'(busy_m));
      check("a_valid", 64'(a_v), 64'(busy_m));
      check("b_busy", 64'(b_busy), 64'(busy_m));
      check("b_valid", 64'(b_v), 64'(busy_m));
      if (busy_m) begin
         e = exp_q[0];
         check("a_idx", 64'(a_idx), 64'(e.idx));
         check("a_count", 64'(a_cnt), 64'(e.cnt_a));
         check("a_pc", 64'(a_pc), 64'(e.pc));
         check("a_last", 64'(a_last), 64'(e.last));
         check("b_idx", 64'(b_idx), 64'(e.idx));
         check("b_count", 64'(b_cnt), 64'(e.cnt_b));
         check("b_pc", 64'(b_pc), 64'(e.pc));
         check("b_last", 64'(b_last), 64'(e.last));
      end
   endtask

   task automatic model_step();
      logic   was_busy;
      int     b;
      entry_t e;
      if (!rst_n) begin
         model_reset();
         return;
      end
      was_busy = (exp_q.size() != 0);
      if (was_busy && ready) e = exp_q.pop_front();
      if (!was_busy && trig) begin
         for (int i = 0; i < bins_lp; i++) begin
            e.idx   = 6'(i);
            e.cnt_a = live_a[i];
            e.cnt_b = live_b[i];
            e.pc    = lpc[i];
            e.last  = (i == nt_lp);
            exp_q.push_back(e);
            live_a[i] = '0;
         end
      end
      if (!stall && typ != 32'd31) begin
         b = (typ < 32'(nt_lp)) ? int'(typ) : nt_lp;
         if (live_a[b] != 32'hFFFF_FFFF) live_a[b] = live_a[b] + 32'd1;
         if (live_b[b] != 4'hF)          live_b[b] = live_b[b] + 4'd1;
         lpc[b] = pc;
      end
   endtask

   task automatic tick();
      compare_outputs();
      model_step();
      @(negedge clk);
   endtask

   // driver tasks
   task automatic drive(input logic s, input logic [31:0] t, input logic [31:0] p,
                        input logic tr, input logic rd);
      stall = s; typ = t; pc = p; trig = tr; ready = rd;
      tick();
   endtask

   task automatic idle(input int n, input logic rd);
      for (int i = 0; i < n; i++) drive(1'b0, 32'd31, $urandom, 1'b0, rd);
   endtask

   task automatic dump_all();
      drive(1'b0, 32'd31, 32'h0, 1'b1, 1'b1);
      idle(36, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; typ = 32'd31; pc = '0; trig = 1'b0; ready = 1'b0;
      repeat (2) @(negedge clk);
      model_reset();
      check("rst_a_busy", 64'(a_busy), 64'd0);
      check("rst_a_valid", 64'(a_v), 64'd0);
      check("rst_a_idx", 64'(a_idx), 64'd0);
      check("rst_a_count", 64'(a_cnt), 64'd0);
      check("rst_a_pc", 64'(a_pc), 64'd0);
      check("rst_a_last", 64'(a_last), 64'd0);
      check("rst_b_valid", 64'(b_v), 64'd0);
      check("rst_b_count", 64'(b_cnt), 64'd0);
      rst_n = 1'b1;

      // count and last PC
      for (int i = 0; i < 5; i++) drive(1'b0, 32'd3, 32'h100 + 32'(4 * i), 1'b0, 1'b1);
      dump_all();

      // stall gating and the no-bubble code
      for (int i = 0; i < 4; i++) drive(1'b1, 32'd2, $urandom, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) drive(1'b0, 32'd2, $urandom, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) drive(1'b0, 32'd31, $urandom, 1'b0, 1'b1);
      dump_all();

      // unknown bin
      for (int i = 0; i < 3; i++) drive(1'b0, 32'h40, $urandom, 1'b0, 1'b1);
      dump_all();

      // backpressure with a mid-dump trigger that must be ignored
      for (int i = 0; i < 8; i++) drive(1'b0, 32'($urandom_range(0, 40)), $urandom, 1'b0, 1'b1);
      drive(1'b0, 32'd5, $urandom, 1'b1, 1'b1);
      for (int i = 0; i < 80; i++)
         drive(1'b0, 32'($urandom_range(0, 40)), $urandom, 1'(i == 10), 1'(i % 2 == 0));
      idle(4, 1'b1);

      // trigger-cycle event, then a dump with no new events
      for (int i = 0; i < 6; i++) drive(1'b0, 32'd1, $urandom, 1'b0, 1'b1);
      drive(1'b0, 32'd1, $urandom, 1'b1, 1'b1);
      idle(36, 1'b1);
      dump_all();

      // saturation, then reset in the middle of a dump
      for (int i = 0; i < 20; i++) drive(1'b0, 32'd0, $urandom, 1'b0, 1'b1);
      drive(1'b0, 32'd31, 32'h0, 1'b1, 1'b1);
      idle(5, 1'b1);
      rst_n = 1'b0;
      idle(1, 1'b1);
      rst_n = 1'b1;
      idle(3, 1'b1);
      dump_all();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 499) != 0);
         drive(1'($urandom_range(0, 3) == 0),
               ($urandom_range(0, 9) == 0) ? 32'($urandom_range(32, 300)) : 32'($urandom_range(0, 31)),
               $urandom, 1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0));
      end
      rst_n = 1'b1;
      idle(80, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
